// File: rtl/ram_rd_pkg.sv
// Shared types and sizing helpers for the RAM stream reader.
// The FSM state type is exposed here so checkers can bind to it by name.
package ram_rd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } rd_state_e;

  // One slot per read that can be in the RAM pipeline, plus one so a beat
  // can sit at the head while the next read is still returning.
  function automatic int fifo_depth(input int rd_latency);
    return rd_latency + 1;
  endfunction

endpackage

// File: rtl/rd_skid_fifo.sv
// Small shift-register FIFO: entry 0 is always the head, so head outputs come
// straight from flops. Push and pop may happen together in any fill state.
module rd_skid_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             not_empty,
  output logic [CNT_W-1:0] count
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] wr_idx;
  logic             do_pop, do_push;

  assign do_pop  = pop && (cnt_q != '0);
  assign do_push = push && ((cnt_q != CNT_W'(DEPTH)) || do_pop);

  // Popping shifts everything toward the head and zero-fills the tail, so an
  // empty FIFO presents all-zero head data.
  always_comb begin
    mem_d  = mem_q;
    wr_idx = IDX_W'(cnt_q);
    if (do_pop) begin
      for (int i = 0; i < DEPTH - 1; i++) mem_d[i] = mem_q[i+1];
      mem_d[DEPTH-1] = '0;
      wr_idx = IDX_W'(cnt_q - CNT_W'(1));
    end
    if (do_push) mem_d[wr_idx] = push_data;
    cnt_d = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      cnt_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
      cnt_q <= cnt_d;
    end
  end

  assign head_data = mem_q[0];
  assign not_empty = (cnt_q != '0);
  assign count     = cnt_q;

endmodule

// File: rtl/ram_stream_reader.sv
// Walks a contiguous RAM address range and streams the words out on a
// valid/ready port, absorbing RAM read latency in a credit-guarded skid FIFO.
//
// Handshake: a beat transfers on any cycle where m_valid & m_ready are both
// high; once m_valid rises, m_valid/m_data/m_last hold until that transfer.
module ram_stream_reader
  import ram_rd_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
  output logic                  busy,
  output logic                  done,
  output logic                  ram_re,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  input  logic [DATA_WIDTH-1:0] ram_dout,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last
);

  localparam int DEPTH = fifo_depth(RD_LATENCY);
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic                  last;
    logic [DATA_WIDTH-1:0] data;
  } fifo_entry_t;

  rd_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0] next_addr_q, held_addr_q;
  logic [ADDR_WIDTH:0]   remaining_q;
  logic [RD_LATENCY-1:0] vpipe_q, lpipe_q;
  logic                  issue, issue_last, fifo_pop, fifo_not_empty, credit_ok;
  logic [CNT_W-1:0]      fifo_count;
  logic [CNT_W:0]        in_flight, pending;
  fifo_entry_t           push_entry, head_entry;

  always_comb begin
    in_flight = '0;
    for (int i = 0; i < RD_LATENCY; i++) in_flight = in_flight + (CNT_W+1)'(vpipe_q[i]);
  end

  // A beat leaving the FIFO this cycle frees its slot immediately, which is
  // what lets the stream sustain one beat per cycle under constant ready.
  assign pending   = (CNT_W+1)'(fifo_count) + in_flight - (CNT_W+1)'(fifo_pop);
  assign credit_ok = pending < (CNT_W+1)'(DEPTH);

  always_comb begin
    state_d    = state_q;
    issue      = 1'b0;
    issue_last = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = (length == '0) ? FIN : READ;
      end
      READ: begin
        if ((remaining_q != '0) && credit_ok) begin
          issue      = 1'b1;
          issue_last = (remaining_q == (ADDR_WIDTH+1)'(1));
          if (issue_last) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (fifo_pop && head_entry.last) state_d = FIN;
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      next_addr_q <= '0;
      held_addr_q <= '0;
      remaining_q <= '0;
      vpipe_q     <= '0;
      lpipe_q     <= '0;
    end else begin
      state_q <= state_d;
      if ((state_q == IDLE) && start) begin
        next_addr_q <= base_addr;
        remaining_q <= length;
      end else if (issue) begin
        next_addr_q <= next_addr_q + ADDR_WIDTH'(1);
        held_addr_q <= next_addr_q;
        remaining_q <= remaining_q - (ADDR_WIDTH+1)'(1);
      end
      // Return-valid pipeline: bit RD_LATENCY-1 marks ram_dout as valid now.
      vpipe_q[0] <= issue;
      lpipe_q[0] <= issue_last;
      for (int i = 1; i < RD_LATENCY; i++) begin
        vpipe_q[i] <= vpipe_q[i-1];
        lpipe_q[i] <= lpipe_q[i-1];
      end
    end
  end

  assign push_entry = '{last: lpipe_q[RD_LATENCY-1], data: ram_dout};
  assign fifo_pop   = fifo_not_empty && m_ready;

  rd_skid_fifo #(
    .WIDTH ($bits(fifo_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (vpipe_q[RD_LATENCY-1]),
    .push_data (push_entry),
    .pop       (fifo_pop),
    .head_data (head_entry),
    .not_empty (fifo_not_empty),
    .count     (fifo_count)
  );

  assign busy     = (state_q != IDLE);
  assign done     = (state_q == FIN);
  assign ram_re   = issue;
  assign ram_addr = issue ? next_addr_q : held_addr_q;
  assign m_valid  = fifo_not_empty;
  assign m_data   = head_entry.data;
  assign m_last   = head_entry.last;

endmodule
